pcm2pdm: RTL and testbench
==========================

PCM2PDM -- requirements
Module: pcm2pdm

Interface
REQ-001 Parameter R, default 24, interpolation factor: clk cycles per PCM sample.
REQ-002 Parameter N, default 4, number of CIC comb and integrator stages; M fixed at 1.
REQ-003 Parameter IN_WIDTH, default 16, signed PCM input width.
REQ-004 Parameter ACC_WIDTH, default 36, internal CIC width; must be at least IN_WIDTH + N*clog2(R).
REQ-005 Parameter SHIFT, default 14, arithmetic right shift applied to CIC output; gain is R^(N-1)/2^SHIFT = 13824/16384.
REQ-006 Port clk  input  1  single clock; PDM bit rate; all logic is on the rising edge.
REQ-007 Port reset_n  input  1  reset, synchronous, active-low.
REQ-008 Port din  input  IN_WIDTH  signed two's-complement PCM sample.
REQ-009 Port din_valid  input  1  din is presented.
REQ-010 Port din_ready  output  1  input holding register is empty.
REQ-011 Port pdm_out  output  1  registered PDM bit; 1 means +full-scale, 0 means -full-scale.
REQ-012 Port underrun  output  1  one-cycle pulse: a sample slot passed with no new sample.

Function
REQ-013 A sample is accepted on any cycle with din_valid=1 and din_ready=1; it goes into a one-entry holding register.
REQ-014 din_ready = holding register empty; it depends only on registered state, never on din_valid.
REQ-015 Phase counter counts 0..R-1, wraps to 0, and advances every cycle; strobe = (phase == R-1).
REQ-016 On strobe with the holding register full, the comb input is the held sample and the register empties at that edge; din_ready=1 on the next cycle.
REQ-017 On strobe with the holding register empty, the comb input is the last consumed sample (0 after reset), and underrun=1 for the following cycle only.
REQ-018 Accept and strobe in the same cycle: the sample fills the register, underrun still fires, and the sample is consumed at the next strobe.
REQ-019 Comb chain runs only at strobe, N cascaded stages, each y = x - x_prev; the result is registered into comb_out.
REQ-020 A one-cycle stuff flag is set after each strobe.
REQ-021 Integrator 0 adds comb_out (sign-extended) when the stuff flag is set, else adds 0 (zero-stuffing).
REQ-022 Integrator k adds integrator k-1 every cycle, for k = 1..N-1.
REQ-023 All CIC arithmetic wraps modulo 2^ACC_WIDTH.
REQ-024 y = integrator[N-1] >>> SHIFT, saturated to the IN_WIDTH signed range.
REQ-025 The modulator is first-order error feedback with an 18-bit signed accumulator sd_acc.
REQ-026 fb = pdm_out ? +32768 : -32768.
REQ-027 sd_next = sd_acc + y + dither - fb; sd_acc <= sd_next.
REQ-028 pdm_out <= (sd_next >= 0).
REQ-029 The modulator updates every cycle; no cycle is skipped at strobe.

Reset
REQ-030 When reset_n=0 at a rising edge, the following are cleared: phase, holding register, last sample, comb delays, comb_out, stuff flag, integrators, sd_acc.
REQ-031 Reset values: pdm_out=0, underrun=0, din_ready=1.
REQ-032 Reset mid-operation discards a held sample with no underrun pulse; operation restarts at phase 0 on the first cycle with reset_n=1.

Configuration
REQ-033 Macro PCM2PDM_DITHER_EN defined: a 16-bit Fibonacci LFSR is present (taps 16,14,13,11; seed 0xACE1 at reset; advances every cycle).
REQ-034 With PCM2PDM_DITHER_EN defined: dither = lfsr[3:0] - 8, range -8..+7.
REQ-035 PCM2PDM_DITHER_EN undefined: no LFSR logic is present and dither = 0.

Verification
REQ-036 Reset then din_valid=0 for 240 cycles -> underrun pulses exactly 10 times, one cycle after each phase=23; pdm_out ones count 120 +/- 2.
REQ-037 Constant din=32767 supplied every slot, 500 slots settling, then 2400-cycle window -> ones density 0.922 +/- 0.01; underrun never pulses.
REQ-038 Constant din=-32768, same windows as REQ-037 -> ones density 0.078 +/- 0.01.
REQ-039 din_valid held high -> din_ready falls the cycle after accept and rises the cycle after each strobe; exactly one accept per 24 cycles; no underrun after the first slot.
REQ-040 Drive din_valid=1 only on the phase=23 cycle -> underrun pulses on the next cycle and the sample is consumed at the next strobe.
REQ-041 reset_n=0 for one cycle mid-stream with the register full -> next cycle: pdm_out=0, din_ready=1, underrun=0, phase=0.

Source files
------------

// File: rtl/pcm2pdm.sv
// pcm2pdm: PCM to 1-bit PDM via a zero-stuffed CIC interpolator and a first-order modulator.
// Define PCM2PDM_DITHER_EN to add a 16-bit LFSR dither (-8..+7) into the modulator.
module pcm2pdm #(
  parameter int R         = 24,
  parameter int N         = 4,
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 36,
  parameter int SHIFT     = 14
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic signed [IN_WIDTH-1:0] din,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic                       pdm_out,
  output logic                       underrun
);

  localparam int PW   = (R > 1) ? $clog2(R) : 1;
  localparam int SD_W = 18;

  localparam logic signed [ACC_WIDTH-1:0] Y_MAX =
    {{(ACC_WIDTH-IN_WIDTH+1){1'b0}}, {(IN_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] Y_MIN =
    {{(ACC_WIDTH-IN_WIDTH+1){1'b1}}, {(IN_WIDTH-1){1'b0}}};
  localparam logic signed [SD_W-1:0] FB_POS = 18'sd32768;
  localparam logic signed [SD_W-1:0] FB_NEG = -18'sd32768;

  logic [PW-1:0]                phase;
  logic                         strobe;
  logic                         full;
  logic                         accept;
  logic signed [IN_WIDTH-1:0]   hold;
  logic signed [IN_WIDTH-1:0]   last;
  logic signed [IN_WIDTH-1:0]   sample_in;
  logic signed [ACC_WIDTH-1:0]  comb_x   [N+1];
  logic signed [ACC_WIDTH-1:0]  comb_dly [N];
  logic signed [ACC_WIDTH-1:0]  comb_out;
  logic                         stuff;
  logic signed [ACC_WIDTH-1:0]  integ    [N];
  logic signed [ACC_WIDTH-1:0]  shifted;
  logic signed [IN_WIDTH-1:0]   y;
  logic signed [SD_W-1:0]       y_ext;
  logic signed [SD_W-1:0]       fb;
  logic signed [SD_W-1:0]       dither;
  logic signed [SD_W-1:0]       sd_acc;
  logic signed [SD_W-1:0]       sd_next;

  assign strobe    = (phase == PW'(R - 1));
  assign din_ready = ~full;
  assign accept    = din_valid & ~full;
  // An empty slot repeats the previously consumed sample (zero after reset).
  assign sample_in = full ? hold : last;

  always_comb begin
    comb_x[0] = {{(ACC_WIDTH-IN_WIDTH){sample_in[IN_WIDTH-1]}}, sample_in};
    for (int k = 0; k < N; k++) begin
      comb_x[k+1] = comb_x[k] - comb_dly[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase    <= '0;
      full     <= 1'b0;
      hold     <= '0;
      last     <= '0;
      underrun <= 1'b0;
      stuff    <= 1'b0;
      comb_out <= '0;
      for (int k = 0; k < N; k++) begin
        comb_dly[k] <= '0;
      end
    end else begin
      phase    <= strobe ? '0 : phase + PW'(1);
      underrun <= strobe & ~full;
      stuff    <= strobe;
      if (strobe && full) begin
        full <= 1'b0;
      end else if (accept) begin
        full <= 1'b1;
        hold <= din;
      end
      if (strobe) begin
        last     <= sample_in;
        comb_out <= comb_x[N];
        for (int k = 0; k < N; k++) begin
          comb_dly[k] <= comb_x[k];
        end
      end
    end
  end

  // Integrators run at the full clock rate; stage 0 sees comb_out only on the stuff cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) begin
        integ[k] <= '0;
      end
    end else begin
      integ[0] <= integ[0] + (stuff ? comb_out : '0);
      for (int k = 1; k < N; k++) begin
        integ[k] <= integ[k] + integ[k-1];
      end
    end
  end

  always_comb begin
    shifted = integ[N-1] >>> SHIFT;
    y       = shifted[IN_WIDTH-1:0];
    if (shifted > Y_MAX) begin
      y = Y_MAX[IN_WIDTH-1:0];
    end else if (shifted < Y_MIN) begin
      y = Y_MIN[IN_WIDTH-1:0];
    end
  end

`ifdef PCM2PDM_DITHER_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign dither  = $signed({14'b0, lfsr[3:0]}) - 18'sd8;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end
`else
  assign dither = '0;
`endif

  always_comb begin
    y_ext   = {{(SD_W-IN_WIDTH){y[IN_WIDTH-1]}}, y};
    fb      = pdm_out ? FB_POS : FB_NEG;
    sd_next = sd_acc + y_ext + dither - fb;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sd_acc  <= '0;
      pdm_out <= 1'b0;
    end else begin
      sd_acc  <= sd_next;
      pdm_out <= ~sd_next[SD_W-1];
    end
  end

endmodule

// File: tb/tb_pcm2pdm.sv
// Bench for pcm2pdm: CIC modelled as an FIR with a boxcar^N kernel over the consumed sample stream,
// compared every cycle against the DUT, plus directed literal checks of timing and density.
module tb_pcm2pdm;

  localparam int R   = 24;
  localparam int N   = 4;
  localparam int INW = 16;
  localparam int ACW = 36;
  localparam int SH  = 14;
  localparam int KL  = N * (R - 1) + 1;
  localparam int HN  = 8;

  logic                  clk;
  logic                  reset_n;
  logic signed [INW-1:0] din;
  logic                  din_valid;
  logic                  din_ready;
  logic                  pdm_out;
  logic                  underrun;

  pcm2pdm #(.R(R), .N(N), .IN_WIDTH(INW), .ACC_WIDTH(ACW), .SHIFT(SH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .pdm_out  (pdm_out),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int compared;
  int mismatched;
  bit chk_en;

  longint h [0:KL-1];

  // model state
  int     m_phase;
  bit     m_full;
  int     m_hold;
  int     m_last;
  bit     m_under;
  bit     m_pdm;
  int     m_sd;
  int     m_t;
  logic [15:0] m_lfsr;
  int     hx [HN];
  int     he [HN];
  int     hist_n;
  int     hist_w;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    compared++;
    if (act < lo || act > hi) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int wrap18(input int v);
    int r;
    r = v & 32'h3FFFF;
    if (r >= 131072) r -= 262144;
    return r;
  endfunction

  // Integrator-chain output after edge t: sum of consumed samples through the interpolation kernel.
  function automatic int model_y(input int t);
    longint acc;
    longint q;
    int d;
    acc = 0;
    for (int k = 0; k < hist_n; k++) begin
      d = t - he[k] - 4;
      if (d >= 0 && d < KL) acc += longint'(hx[k]) * h[d];
    end
    q = acc >>> SH;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  task automatic model_edge();
    int y, dith, fbv, sdn, val;
    bit strobe, acc;
    if (!reset_n) begin
      m_phase = 0; m_full = 0; m_hold = 0; m_last = 0; m_under = 0;
      m_pdm = 0; m_sd = 0; m_t = 0; hist_n = 0; hist_w = 0;
      m_lfsr = 16'hACE1;
      return;
    end
    y = model_y(m_t);
`ifdef PCM2PDM_DITHER_EN
    dith = int'(m_lfsr[3:0]) - 8;
`else
    dith = 0;
`endif
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    fbv = m_pdm ? 32768 : -32768;
    sdn = wrap18(m_sd + y + dith - fbv);
    m_sd = sdn;
    m_pdm = (sdn >= 0);
    strobe = (m_phase == R - 1);
    acc = din_valid && !m_full;
    if (strobe) begin
      val = m_full ? m_hold : m_last;
      m_last = val;
      hx[hist_w] = val;
      he[hist_w] = m_t + 1;
      hist_w = (hist_w + 1) % HN;
      if (hist_n < HN) hist_n++;
      m_under = !m_full;
      if (m_full) m_full = 0;
      else if (acc) begin m_full = 1; m_hold = int'(din); end
    end else begin
      m_under = 0;
      if (acc) begin m_full = 1; m_hold = int'(din); end
    end
    m_phase = (m_phase + 1) % R;
    m_t++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (chk_en) begin
      check("pdm_out", int'(pdm_out), int'(m_pdm));
      check("din_ready", int'(din_ready), int'(!m_full));
      check("underrun", int'(underrun), int'(m_under));
    end
  endtask

  task automatic do_reset();
    reset_n = 0;
    din_valid = 0;
    tick();
    tick();
    chk_en = 1;
    check("rst_pdm_out", int'(pdm_out), 0);
    check("rst_din_ready", int'(din_ready), 1);
    check("rst_underrun", int'(underrun), 0);
    reset_n = 1;
  endtask

  initial begin
    int ones, unders, accs, cnt, len;
    bit got;
    int vals [8];
    longint tmp [0:KL-1];
    longint ksum;

    clk = 0; reset_n = 0; din = '0; din_valid = 0; chk_en = 0;
    compared = 0; mismatched = 0;
    hist_n = 0; hist_w = 0; m_t = 0;
    vals = '{1000, -2000, 30000, -32768, 32767, 0, 123, -5};

    for (int i = 0; i < KL; i++) h[i] = (i < R) ? 1 : 0;
    len = R;
    for (int s = 1; s < N; s++) begin
      for (int i = 0; i < KL; i++) tmp[i] = 0;
      for (int i = 0; i < len; i++)
        for (int j = 0; j < R; j++) tmp[i+j] += h[i];
      len += R - 1;
      for (int i = 0; i < KL; i++) h[i] = tmp[i];
    end
    ksum = 0;
    for (int i = 0; i < KL; i++) ksum += h[i];
    check("kernel_sum", int'(ksum), 331776);

    // idle stream: underrun every slot, modulator idles near 50 %
    do_reset();
    ones = 0; unders = 0;
    for (int i = 0; i < 240; i++) begin
      tick();
      ones += int'(pdm_out);
      unders += int'(underrun);
    end
    check("idle_underruns", unders, 10);
    check_range("idle_ones", ones, 118, 122);

    // valid held high with changing samples: one accept per slot
    do_reset();
    din_valid = 1;
    din = INW'(vals[0]);
    accs = 0; unders = 0;
    for (int i = 0; i < 240; i++) begin
      got = din_ready;
      tick();
      unders += int'(underrun);
      if (got) begin
        accs++;
        check("ready_drop_after_accept", int'(din_ready), 0);
        din = INW'(vals[accs % 8]);
      end
    end
    check("accepts_per_240", accs, 10);
    check("stream_underruns", unders, 0);

    // sample offered only in the strobe cycle
    do_reset();
    din_valid = 0;
    for (int i = 0; i < 30 && m_phase != R - 1; i++) tick();
    check("reach_phase23", m_phase, R - 1);
    din_valid = 1;
    din = -16'sd1234;
    tick();
    din_valid = 0;
    check("late_underrun", int'(underrun), 1);
    check("late_ready_low", int'(din_ready), 0);
    cnt = 0;
    for (int i = 0; i < R - 1; i++) begin
      tick();
      cnt += int'(!din_ready);
    end
    check("late_held_cycles", cnt, R - 1);
    tick();
    check("late_consumed_ready", int'(din_ready), 1);
    check("late_consumed_no_underrun", int'(underrun), 0);

    // full-scale positive
    do_reset();
    din_valid = 1;
    din = 16'sd32767;
    for (int i = 0; i < 500 * R; i++) tick();
    check("model_dc_pos", model_y(m_t), 27647);
    ones = 0; unders = 0;
    for (int i = 0; i < 2400; i++) begin
      tick();
      ones += int'(pdm_out);
      unders += int'(underrun);
    end
    check_range("pos_density_ones", ones, 2189, 2237);
    check("pos_underruns", unders, 0);

    // full-scale negative
    do_reset();
    din_valid = 1;
    din = -16'sd32768;
    for (int i = 0; i < 500 * R; i++) tick();
    check("model_dc_neg", model_y(m_t), -27648);
    ones = 0; unders = 0;
    for (int i = 0; i < 2400; i++) begin
      tick();
      ones += int'(pdm_out);
      unders += int'(underrun);
    end
    check_range("neg_density_ones", ones, 163, 211);
    check("neg_underruns", unders, 0);

    // one-cycle reset while the holding register is full
    do_reset();
    din_valid = 1;
    din = 16'sd777;
    for (int i = 0; i < 30; i++) tick();
    for (int i = 0; i < 30 && din_ready; i++) tick();
    check("pre_reset_full", int'(din_ready), 0);
    reset_n = 0;
    din_valid = 0;
    tick();
    check("midrst_pdm_out", int'(pdm_out), 0);
    check("midrst_din_ready", int'(din_ready), 1);
    check("midrst_underrun", int'(underrun), 0);
    reset_n = 1;
    cnt = 0;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      cnt++;
      got = underrun;
    end
    check("midrst_first_underrun_cycle", cnt, R);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
